seq_div: RTL and testbench

- Sequential signed restoring divider; the inverse datapath of the team's sequential shift-add multiplier.
- Uses the same level-held start/ready handshake.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands, one quotient bit per clock.
- Sits beside the multiplier in the lab arithmetic unit.

---
 rtl/seq_div_pkg.sv | 20 ++
 rtl/seq_div_if.sv | 37 +++
 rtl/seq_div_div_step.sv | 25 ++
 rtl/seq_div.sv | 168 ++++++++++++++++
 tb/tb_seq_div.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding, default width, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Step counter width: must hold 0..WIDTH-1 with headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_div_if.sv
// Divider request/result bundle: start/A/B towards the divider, quotient/remainder/ready/div_by_zero back.
// Latency: n/a (wires only).
// Backpressure: level-held start; result is held for as long as start stays high.
// Optional: SEQ_DIV_OVERFLOW_FLAG_EN adds the overflow result bit.
interface seq_div_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             div_by_zero;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    modport master (
        output start, A, B,
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
        input  overflow,
`endif
        input  quotient, remainder, ready, div_by_zero
    );

    modport slave (
        input  start, A, B,
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
        output overflow,
`endif
        output quotient, remainder, ready, div_by_zero
    );

endinterface

// File: rtl/seq_div_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor, keep or restore.
// Latency: combinational.
// Backpressure: none.
// Ports: pr_in/pr_out partial remainder (WIDTH+1), dvd_bit next dividend bit, dm divisor magnitude, q_bit quotient bit.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] pr_in,
    input  logic           dvd_bit,
    input  logic [WIDTH:0] dm,
    output logic [WIDTH:0] pr_out,
    output logic           q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {pr_in, dvd_bit};
        diff    = shifted - {1'b0, dm};
        // Top bit of the difference is the borrow: clear means the divisor fits.
        q_bit   = ~diff[WIDTH+1];
        pr_out  = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential signed restoring divider, one quotient bit per clock; quotient truncates toward zero, remainder follows dividend sign.
// Latency: ready after WIDTH+2 edges from the first edge sampling start (2 edges on divide by zero).
// Backpressure: start is level-held; dropping it in any busy/done state clears outputs and returns to IDLE next edge.
// Ports: clk, reset (sync, active-low), bus (seq_div_if.slave). Optional: SEQ_DIV_OVERFLOW_FLAG_EN adds bus.overflow.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    seq_div_if.slave  bus
);
    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;          // raw dividend, returned as remainder on divide by zero
    logic [WIDTH-1:0] acc_q, acc_d;      // dividend magnitude shifting out, quotient magnitude shifting in
    logic [WIDTH:0]   dm_q, dm_d;        // divisor magnitude
    logic [WIDTH:0]   pr_q, pr_d;        // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             ready_q, ready_d;
    logic             dz_q, dz_d;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH:0]   step_pr;
    logic             step_q;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Unsigned WIDTH-bit magnitudes are exact even for the most negative operand.
    assign a_abs = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
    assign b_abs = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr_in   (pr_q),
        .dvd_bit (acc_q[WIDTH-1]),
        .dm      (dm_q),
        .pr_out  (step_pr),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        acc_d       = acc_q;
        dm_d        = dm_q;
        pr_d        = pr_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = ready_q;
        dz_d        = dz_q;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
        ovf_d       = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = bus.A;
                    acc_d     = a_abs;
                    dm_d      = {1'b0, b_abs};
                    neg_quo_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    neg_rem_d = bus.A[WIDTH-1];
                    pr_d      = '0;
                    cnt_d     = '0;
                    state_d   = (bus.B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                pr_d  = step_pr;
                acc_d = {acc_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dm_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dz_d        = 1'b1;
                end else begin
                    // Negating 2^(WIDTH-1) wraps to itself, which is the intended overflow result.
                    quotient_d  = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
                    remainder_d = neg_rem_q ? (~pr_q[WIDTH-1:0] + 1'b1) : pr_q[WIDTH-1:0];
                end
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
                // neg_quo ^ neg_rem is the divisor sign; |B|==1 with B negative means B==-1.
                ovf_d = (a_q == MIN_VAL) && (dm_q == (WIDTH+1)'(1)) && (neg_quo_q != neg_rem_q);
`endif
                ready_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // Result held while start stays high.
            end
            default: state_d = IDLE;
        endcase

        // Dropping start aborts a calculation or acknowledges a finished result.
        if ((state_q != IDLE) && !bus.start) begin
            state_d     = IDLE;
            quotient_d  = '0;
            remainder_d = '0;
            ready_d     = 1'b0;
            dz_d        = 1'b0;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
            ovf_d       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            acc_q       <= '0;
            dm_q        <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            dz_q        <= 1'b0;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            dm_q        <= dm_d;
            pr_q        <= pr_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            dz_q        <= dz_d;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.ready       = ready_q;
    assign bus.div_by_zero = dz_q;
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
    assign bus.overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed vector table, multi-cycle corner sequences, random ops against an arithmetic model.
// Latency: checks ready edge count (WIDTH+2 normal, 2 on divide by zero).
// Backpressure: exercises start hold, abort, acknowledge and reset interplay.
module tb_seq_div;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_div_if #(.WIDTH(W)) bus ();
    seq_div    #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating) and modulo, wrapped to W bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = W'(ia / ib);
            r  = W'(ia % ib);
            dz = 1'b0;
        end
    endtask

    // Called on a negedge with start low for at least one prior edge; returns on a negedge with start low.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] qe, input logic [W-1:0] re, input logic dze,
                          input int lat_e, input bit scramble, input string tag);
        int   n;
        logic got;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = bus.ready;
            if (scramble && n == 1) begin
                bus.A = '0;
                bus.B = '0;
            end
        end
        check({tag, ".lat"}, n, lat_e);
        check({tag, ".quo"}, bus.quotient, qe);
        check({tag, ".rem"}, bus.remainder, re);
        check({tag, ".dz"},  bus.div_by_zero, dze);
`ifdef SEQ_DIV_OVERFLOW_FLAG_EN
        check({tag, ".ovf"}, bus.overflow, (a == 8'h80 && b == 8'hFF));
`endif
        repeat (2) @(negedge clk);
        check({tag, ".hold"}, {bus.ready, bus.quotient, bus.remainder}, {1'b1, qe, re});
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, ".clr"}, {bus.ready, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rq;
        logic [W-1:0] rr;
        logic         rdz;
        logic         seen;

        tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 10};
        tbl[1]  = '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 10};
        tbl[2]  = '{8'd100, 8'hF9,  8'hF2,  8'h02,  1'b0, 10};
        tbl[3]  = '{8'd5,   8'd0,   8'hFF,  8'h05,  1'b1, 2};
        tbl[4]  = '{8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 10};
        tbl[5]  = '{8'h7F,  8'h01,  8'h7F,  8'h00,  1'b0, 10};
        tbl[6]  = '{8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 10};
        tbl[7]  = '{8'h00,  8'h05,  8'h00,  8'h00,  1'b0, 10};
        tbl[8]  = '{8'h80,  8'h00,  8'hFF,  8'h80,  1'b1, 2};
        tbl[9]  = '{8'h01,  8'h80,  8'h00,  8'h01,  1'b0, 10};
        tbl[10] = '{8'h80,  8'h7F,  8'hFF,  8'hFF,  1'b0, 10};
        tbl[11] = '{8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 10};
        tbl[12] = '{8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 10};
        tbl[13] = '{8'h80,  8'h02,  8'hC0,  8'h00,  1'b0, 10};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        check("reset.outs", {bus.ready, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle.outs", {bus.ready, bus.div_by_zero, bus.quotient, bus.remainder}, 0);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat, 1'b0,
                   $sformatf("tbl%0d", i));
        end

        // Abort after 4 edges: ready must never rise, then a clean restart.
        bus.A     = 8'd100;
        bus.B     = 8'd7;
        bus.start = 1'b1;
        seen      = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.ready;
        end
        bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | bus.ready;
        end
        check("abort.ready", seen, 0);
        check("abort.outs", {bus.quotient, bus.remainder}, 0);
        run_op(8'd127, 8'd1, 8'd127, 8'd0, 1'b0, 10, 1'b0, "restart");

        // Reset on edge 5 of a run, start still high: reset wins, then IDLE with normal latency.
        bus.A     = 8'd100;
        bus.B     = 8'd7;
        bus.start = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid.outs", {bus.ready, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 1'b0, "after_rst");

        // Reset while a divide-by-zero result is being held.
        bus.A     = 8'd5;
        bus.B     = 8'd0;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        check("rstdone.pre", {bus.ready, bus.div_by_zero}, 2'b11);
        reset = 1'b0;
        @(negedge clk);
        check("rstdone.outs", {bus.ready, bus.div_by_zero, bus.quotient, bus.remainder}, 0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);

        // Operand changes after the IDLE sample are ignored.
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 1'b1, "scramble");

        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 8'h80;
            model(ra, rb, rq, rr, rdz);
            run_op(ra, rb, rq, rr, rdz, rdz ? 2 : W + 2, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
